// File: rtl/ball_physics.sv
// Volleyball ball motion engine: per-tick gravity, body hits, net/wall/ceiling bounces
// and ground-contact scoring. Positions are Q12.4 pixels, velocities are signed Q6.4.
`timescale 1ns/1ps
module ball_physics #(
  parameter int VBUF_W     = 320,
  parameter int GROUND_Y   = 220,
  parameter int NET_POS    = 160,
  parameter int NET_W      = 6,
  parameter int NET_TOP    = 160,
  parameter int BALL_W     = 20,
  parameter int BALL_H     = 20,
  parameter int PIKA_W     = 41,
  parameter int PIKA_H     = 42,
  parameter int TICK_DIV   = 1666667,
  parameter int GRAVITY    = 2,
  parameter int VY_MAX     = 96,
  parameter int HIT_VY     = 112,
  parameter int HIT_VX     = 48,
  parameter int SERVE_X_P  = 40,
  parameter int SERVE_X_N  = 260,
  parameter int SERVE_Y    = 40,
  parameter int HOLD_TICKS = 60
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        serve_btn,
  input  logic [11:0] player_pos_x,
  input  logic [11:0] player_pos_y,
  input  logic [11:0] npc_pos_x,
  input  logic [11:0] npc_pos_y,
  output logic [11:0] ball_pos_x,
  output logic [11:0] ball_pos_y,
  output logic [1:0]  ball_state,
  output logic        point_player,
  output logic        point_npc
);

  typedef enum logic [1:0] {
    ST_SERVE  = 2'd0,
    ST_FLIGHT = 2'd1,
    ST_SCORED = 2'd2
  } state_t;

  typedef logic signed [16:0] q17_t;
  typedef logic signed [19:0] wide_t;
  typedef logic signed [9:0]  vel_t;

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);

  // Geometry in Q4 units; comparisons run 20 bits wide so parked bodies cannot overflow.
  localparam wide_t W_BW      = wide_t'(BALL_W * 16);
  localparam wide_t W_BH      = wide_t'(BALL_H * 16);
  localparam wide_t W_BW_HALF = wide_t'(BALL_W * 8);
  localparam wide_t W_PW      = wide_t'(PIKA_W * 16);
  localparam wide_t W_PH      = wide_t'(PIKA_H * 16);
  localparam wide_t W_PW_HALF = wide_t'(PIKA_W * 8);
  localparam wide_t W_GROUND  = wide_t'(GROUND_Y * 16);
  localparam wide_t W_NET_C   = wide_t'(NET_POS * 16);
  localparam wide_t W_NET_L   = wide_t'((NET_POS - NET_W / 2) * 16);
  localparam wide_t W_NET_R   = wide_t'((NET_POS + NET_W / 2) * 16);
  localparam wide_t W_NET_TOP = wide_t'(NET_TOP * 16);
  localparam wide_t W_X_MAX   = wide_t'((VBUF_W - BALL_W) * 16);

  localparam q17_t        Q_GRAV     = q17_t'(GRAVITY);
  localparam q17_t        Q_VY_MAX   = q17_t'(VY_MAX);
  localparam vel_t        V_HIT_VY   = vel_t'(HIT_VY);
  localparam vel_t        V_HIT_VX   = vel_t'(HIT_VX);
  localparam logic [15:0] P_SERVE_XP = 16'(SERVE_X_P * 16);
  localparam logic [15:0] P_SERVE_XN = 16'(SERVE_X_N * 16);
  localparam logic [15:0] P_SERVE_Y  = 16'(SERVE_Y * 16);

  state_t        state_q, state_d;
  logic          server_npc_q, server_npc_d;
  logic [15:0]   pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  vel_t          vx_q, vx_d, vy_q, vy_d;
  logic [TW-1:0] tick_q;
  logic [HW-1:0] hold_q, hold_d;
  logic          point_player_q, point_player_d, point_npc_q, point_npc_d;
  logic          tick;

  q17_t  vy_sum, vy_nx, x_nx, y_nx, x_r, y_r;
  wide_t bx, by;
  vel_t  vx_r, vy_r;
  logic  ground, npc_wins, hit_player, hit_npc, net_hit;

  function automatic logic overlaps(input wide_t ax, input wide_t ay,
                                    input logic [11:0] px, input logic [11:0] py);
    wide_t qx, qy;
    qx = wide_t'({px, 4'b0000});
    qy = wide_t'({py, 4'b0000});
    return (ax < qx + W_PW) && (ax + W_BW > qx) && (ay < qy + W_PH) && (ay + W_BH > qy);
  endfunction

  function automatic vel_t hit_vx(input wide_t ax, input logic [11:0] px);
    wide_t qx;
    qx = wide_t'({px, 4'b0000});
    return (ax + W_BW_HALF >= qx + W_PW_HALF) ? V_HIT_VX : -V_HIT_VX;
  endfunction

  function automatic vel_t abs_vel(input vel_t v);
    return (v < 0) ? -v : v;
  endfunction

  assign tick = (tick_q == TICK_LAST);

  // One flight step: integrate, resolve ground/body/net in priority order, then walls.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    vy_sum     = q17_t'(vy_q) + Q_GRAV;
    vy_nx      = (vy_sum > Q_VY_MAX) ? Q_VY_MAX : vy_sum;
    x_nx       = q17_t'({1'b0, pos_x_q}) + q17_t'(vx_q);
    y_nx       = q17_t'({1'b0, pos_y_q}) + vy_nx;
    bx         = wide_t'(x_nx);
    by         = wide_t'(y_nx);
    x_r        = x_nx;
    y_r        = y_nx;
    vx_r       = vx_q;
    vy_r       = vel_t'(vy_nx);
    ground     = 1'b0;
    npc_wins   = 1'b0;
    hit_player = (vy_nx >= 0) && overlaps(bx, by, player_pos_x, player_pos_y);
    hit_npc    = (vy_nx >= 0) && overlaps(bx, by, npc_pos_x, npc_pos_y);
    net_hit    = (bx < W_NET_R) && (bx + W_BW > W_NET_L) &&
                 (by < W_GROUND) && (by + W_BH > W_NET_TOP);

    if (by + W_BH >= W_GROUND) begin
      ground   = 1'b1;
      npc_wins = (bx + W_BW_HALF < W_NET_C);
      y_r      = q17_t'(W_GROUND - W_BH);
      vx_r     = '0;
      vy_r     = '0;
    end else if (hit_player) begin
      vy_r = -V_HIT_VY;
      vx_r = hit_vx(bx, player_pos_x);
    end else if (hit_npc) begin
      vy_r = -V_HIT_VY;
      vx_r = hit_vx(bx, npc_pos_x);
    end else if (net_hit) begin
      if (wide_t'(pos_y_q) + W_BH <= W_NET_TOP) begin
        y_r  = q17_t'(W_NET_TOP - W_BH);
        vy_r = -abs_vel(vel_t'(vy_nx));
      end else begin
        vx_r = -vx_q;
        x_r  = (wide_t'(pos_x_q) + W_BW_HALF < W_NET_C) ? q17_t'(W_NET_L - W_BW)
                                                         : q17_t'(W_NET_R);
      end
    end

    if (x_r < 0) begin
      x_r  = '0;
      vx_r = abs_vel(vx_r);
    end else if (wide_t'(x_r) > W_X_MAX) begin
      x_r  = q17_t'(W_X_MAX);
      vx_r = -abs_vel(vx_r);
    end
    if (y_r < 0) begin
      y_r  = '0;
      vy_r = abs_vel(vy_r);
    end
  end

  always_comb begin
    state_d        = state_q;
    server_npc_d   = server_npc_q;
    pos_x_d        = pos_x_q;
    pos_y_d        = pos_y_q;
    vx_d           = vx_q;
    vy_d           = vy_q;
    hold_d         = hold_q;
    point_player_d = 1'b0;
    point_npc_d    = 1'b0;
    if (tick) begin
      case (state_q)
        ST_SERVE: begin
          pos_x_d = server_npc_q ? P_SERVE_XN : P_SERVE_XP;
          pos_y_d = P_SERVE_Y;
          vx_d    = '0;
          vy_d    = '0;
          if (serve_btn) state_d = ST_FLIGHT;
        end
        ST_FLIGHT: begin
          pos_x_d = x_r[15:0];
          pos_y_d = y_r[15:0];
          vx_d    = vx_r;
          vy_d    = vy_r;
          if (ground) begin
            state_d        = ST_SCORED;
            hold_d         = '0;
            server_npc_d   = npc_wins;
            point_npc_d    = npc_wins;
            point_player_d = !npc_wins;
          end
        end
        ST_SCORED: begin
          if (hold_q == HOLD_LAST) begin
            state_d = ST_SERVE;
            hold_d  = '0;
            pos_x_d = server_npc_q ? P_SERVE_XN : P_SERVE_XP;
            pos_y_d = P_SERVE_Y;
            vx_d    = '0;
            vy_d    = '0;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
        default: state_d = ST_SERVE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_SERVE;
      server_npc_q   <= 1'b0;
      pos_x_q        <= P_SERVE_XP;
      pos_y_q        <= P_SERVE_Y;
      vx_q           <= '0;
      vy_q           <= '0;
      tick_q         <= '0;
      hold_q         <= '0;
      point_player_q <= 1'b0;
      point_npc_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      server_npc_q   <= server_npc_d;
      pos_x_q        <= pos_x_d;
      pos_y_q        <= pos_y_d;
      vx_q           <= vx_d;
      vy_q           <= vy_d;
      tick_q         <= tick ? '0 : tick_q + 1'b1;
      hold_q         <= hold_d;
      point_player_q <= point_player_d;
      point_npc_q    <= point_npc_d;
    end
  end

  assign ball_pos_x   = pos_x_q[15:4];
  assign ball_pos_y   = pos_y_q[15:4];
  assign ball_state   = state_q;
  assign point_player = point_player_q;
  assign point_npc    = point_npc_q;

endmodule
